// File: rtl/negator_stream_driver_if.sv
// Memory and datapath bus seen by the negator stream driver.
// The master side is the driver; the slave side is the memory plus negation datapath.
interface negator_stream_driver_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [63:0]       mem_rd_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [63:0]       mem_wr_data;
   logic              dp_input_valid;
   logic [63:0]       dp_input_data;
   logic              dp_output_valid;
   logic [63:0]       dp_output_data;

   modport master (
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
      output dp_input_valid, dp_input_data,
      input  mem_rd_data, dp_output_valid, dp_output_data
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
      input  dp_input_valid, dp_input_data,
      output mem_rd_data, dp_output_valid, dp_output_data
   );
endinterface

// File: rtl/negator_stream_driver.sv
// Streams 64-bit words from a source region through the negation datapath into a destination
// region, one outstanding datapath transaction at a time, with a response watchdog.
module negator_stream_driver #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LEN_W   = 9,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       src_base,
   input  logic [ADDR_W-1:0]       dst_base,
   input  logic [LEN_W-1:0]        len,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   negator_stream_driver_if.master bus
);
   localparam int unsigned WdW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle, StRead, StWaitRd, StSend, StWaitDp, StWrite, StDone
   } state_t;

   state_t            r_state;
   state_t            w_state_d;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_count;
   logic [63:0]       r_data;
   logic [63:0]       r_result;
   logic [WdW-1:0]    r_wd;
   logic              r_error;
   logic              w_latch;
   logic              w_capture_dp;
   logic              w_timeout;
   logic              w_wd_inc;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_latch      = 1'b0;
      w_capture_dp = 1'b0;
      w_timeout    = 1'b0;
      w_wd_inc     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_latch   = 1'b1;
               w_state_d = (len == '0) ? StDone : StRead;
            end
         end
         StRead:   w_state_d = StWaitRd;
         StWaitRd: w_state_d = StSend;
         StSend:   w_state_d = StWaitDp;
         StWaitDp: begin
            if (bus.dp_output_valid) begin
               w_capture_dp = 1'b1;
               w_state_d    = StWrite;
            end else if (r_wd == WdW'(TIMEOUT - 1)) begin
               // Abandon the remaining beats; a lost response means the datapath is unusable.
               w_timeout = 1'b1;
               w_state_d = StDone;
            end else begin
               w_wd_inc = 1'b1;
            end
         end
         StWrite:  w_state_d = (r_count == LEN_W'(1)) ? StDone : StRead;
         StDone:   w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_count  <= '0;
         r_data   <= '0;
         r_result <= '0;
         r_wd     <= '0;
         r_error  <= 1'b0;
      end else begin
         if (w_latch) begin
            r_src   <= src_base;
            r_dst   <= dst_base;
            r_count <= len;
            r_error <= 1'b0;
         end
         if (r_state == StWaitRd) begin
            r_data <= bus.mem_rd_data;
         end
         if (r_state == StSend) begin
            r_wd <= '0;
         end else if (w_wd_inc) begin
            r_wd <= r_wd + WdW'(1);
         end
         if (w_capture_dp) begin
            r_result <= bus.dp_output_data;
         end
         if (w_timeout) begin
            r_error <= 1'b1;
         end
         if (r_state == StWrite) begin
            r_src   <= r_src + ADDR_W'(1);
            r_dst   <= r_dst + ADDR_W'(1);
            r_count <= r_count - LEN_W'(1);
         end
      end
   end

   // Every output is a register or a pure state decode.
   assign busy               = (r_state != StIdle);
   assign done               = (r_state == StDone);
   assign error              = r_error;
   assign bus.mem_rd_en      = (r_state == StRead);
   assign bus.mem_rd_addr    = r_src;
   assign bus.mem_wr_en      = (r_state == StWrite);
   assign bus.mem_wr_addr    = r_dst;
   assign bus.mem_wr_data    = r_result;
   assign bus.dp_input_valid = (r_state == StSend);
   assign bus.dp_input_data  = r_data;
endmodule
